// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map is indexed [column][row], with column 0 leftmost and row 0 at the top.
package kypd_pkg;

   typedef enum logic [1:0] {
      SCAN_NONE,
      SCAN_SINGLE,
      SCAN_MULTI
   } scan_result_t;

   typedef enum logic [1:0] {
      COL0,
      COL1,
      COL2,
      COL3
   } col_state_t;

   localparam logic [3:0] COL_RESET = 4'b0111;

   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h4, 4'h7, 4'h0},
      '{4'h2, 4'h5, 4'h8, 4'hF},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hB, 4'hC, 4'hD}
   };

endpackage

// File: rtl/kypd_debounce.sv
// Turns per-scan results into one press strobe. A press or release is accepted only
// after DEBOUNCE_SCANS identical scans. key_valid follows the accepting scan edge.
module kypd_debounce
   import kypd_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_vld,
   input  logic [1:0] scan_res,
   input  logic [3:0] scan_code,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   scan_result_t  res;
   scan_result_t  prev_res;
   logic [3:0]    prev_code;
   logic [CW-1:0] stable_cnt;
   logic [CW-1:0] cnt_nxt;
   logic          accept;
   logic          fire;

   assign res = scan_result_t'(scan_res);

   always_comb begin
      cnt_nxt = CW'(1);
      if (res == prev_res && scan_code == prev_code)
         cnt_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CW'(1);
      accept = scan_vld && (cnt_nxt == CNT_MAX);
      // A second key slid onto while held is deliberately ignored.
      fire   = accept && (res == SCAN_SINGLE) && !key_held;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_res   <= SCAN_NONE;
         prev_code  <= 4'h0;
         stable_cnt <= '0;
         key_code   <= 4'h0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         key_valid <= fire;
         if (scan_vld) begin
            prev_res   <= res;
            prev_code  <= scan_code;
            stable_cnt <= cnt_nxt;
         end
         if (fire) begin
            key_code <= scan_code;
            key_held <= 1'b1;
         end else if (accept && res == SCAN_NONE) begin
            key_held <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/kypd_scanner.sv
// Drives the keypad columns one at a time and samples the synchronized rows.
// It classifies each full scan and hands the result to the debouncer.
module kypd_scanner
   import kypd_pkg::*;
#(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_TICKS);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);

   logic [3:0]   row_s1, row_s2;
   col_state_t   state, state_nxt;
   logic [DW-1:0] dwell;
   logic         dwell_last;
   logic [1:0]   acc_cnt;
   logic [3:0]   acc_code;
   logic [2:0]   samp_cnt;
   logic [3:0]   samp_code;
   logic [2:0]   sum;
   logic [1:0]   tot_cnt;
   logic [3:0]   tot_code;
   logic         scan_vld;
   scan_result_t scan_res;
   logic [3:0]   scan_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   assign dwell_last = (dwell == DWELL_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= COL0;
         dwell <= '0;
      end else begin
         state <= state_nxt;
         dwell <= dwell_last ? '0 : dwell + DW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      col_n     = COL_RESET;
      case (state)
         COL0: begin
            col_n = 4'b0111;
            if (dwell_last) state_nxt = COL1;
         end
         COL1: begin
            col_n = 4'b1011;
            if (dwell_last) state_nxt = COL2;
         end
         COL2: begin
            col_n = 4'b1101;
            if (dwell_last) state_nxt = COL3;
         end
         default: begin
            col_n = 4'b1110;
            if (dwell_last) state_nxt = COL0;
         end
      endcase
   end

   // Low-row count saturates at 2: anything beyond one key is simply MULTI.
   always_comb begin
      samp_cnt  = 3'd0;
      samp_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2[r]) begin
            samp_cnt  = samp_cnt + 3'd1;
            samp_code = KEY_MAP[state][2'(3 - r)];
         end
      end
      sum       = {1'b0, acc_cnt} + samp_cnt;
      tot_cnt   = (sum > 3'd1) ? 2'd2 : sum[1:0];
      tot_code  = (samp_cnt != 3'd0) ? samp_code : acc_code;
      scan_vld  = dwell_last && (state == COL3);
      scan_code = 4'h0;
      case (tot_cnt)
         2'd0:    scan_res = SCAN_NONE;
         2'd1: begin
            scan_res  = SCAN_SINGLE;
            scan_code = tot_code;
         end
         default: scan_res = SCAN_MULTI;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'h0;
      end else if (dwell_last) begin
         if (state == COL3) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
         end else begin
            acc_cnt  <= tot_cnt;
            acc_code <= tot_code;
         end
      end
   end

   kypd_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .scan_vld (scan_vld),
      .scan_res (scan_res),
      .scan_code(scan_code),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

endmodule

// File: tb/tb_kypd_scanner.sv
// Scoreboarded bench: a keypad model answers the column drive, and the stimulus queues the expected press codes.
// A monitor pops one expected code for each key_valid strobe and checks its code and latency.
module tb_kypd_scanner;

   localparam int ST      = 8;
   localparam int DS      = 3;
   localparam int SCAN    = 4 * ST;
   localparam int MAX_LAT = (DS + 1) * 4 * ST + 3;

   typedef struct {
      logic [3:0] code;
      int         t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed = 16'h0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Keypad model: a pressed key shorts its row to its column.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c*4+r] && !col_n[3-c]) row_n[3-r] = 1'b0;
   end

   kypd_scanner #(
      .SCAN_TICKS    (ST),
      .DEBOUNCE_SCANS(DS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row_n    (row_n),
      .col_n    (col_n),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [3:0] code);
      exp_q.push_back('{code, cyc});
   endtask

   task automatic press(input int c, input int r);
      pressed[c*4+r] = 1'b1;
   endtask

   task automatic release_key(input int c, input int r);
      pressed[c*4+r] = 1'b0;
   endtask

   task automatic wait_scans(input int n);
      repeat (n * SCAN) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && key_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: key_valid high with code %0h, none expected", key_code);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pulse_code", {28'h0, key_code}, {28'h0, e.code});
            chk("pulse_latency_ok", 32'((cyc - e.t) <= MAX_LAT), 32'd1);
            chk("held_at_pulse", {31'h0, key_held}, 32'd1);
         end
      end
   end

   initial begin
      logic [3:0] pat [4];
      pat[0] = 4'b0111;
      pat[1] = 4'b1011;
      pat[2] = 4'b1101;
      pat[3] = 4'b1110;

      repeat (3) @(negedge clk);
      chk("reset_col_n", {28'h0, col_n}, 32'h7);
      chk("reset_key_code", {28'h0, key_code}, 32'h0);
      chk("reset_key_valid", {31'h0, key_valid}, 32'd0);
      chk("reset_key_held", {31'h0, key_held}, 32'd0);
      rst = 1'b0;

      for (int k = 1; k <= SCAN; k++) begin
         @(negedge clk);
         if (k % ST == ST / 2) chk("idle_col_n", {28'h0, col_n}, {28'h0, pat[k/ST]});
      end
      wait_scans(3);
      chk("idle_key_held", {31'h0, key_held}, 32'd0);
      chk("idle_key_code", {28'h0, key_code}, 32'h0);

      press(1, 1);
      push(4'h5);
      wait_scans(20);
      chk("hold5_pending", exp_q.size(), 32'd0);
      chk("hold5_held", {31'h0, key_held}, 32'd1);
      chk("hold5_code", {28'h0, key_code}, 32'h5);

      release_key(1, 1);
      wait_scans(5);
      chk("release5_held", {31'h0, key_held}, 32'd0);
      press(3, 3);
      push(4'hD);
      wait_scans(6);
      chk("pressD_pending", exp_q.size(), 32'd0);
      chk("pressD_code", {28'h0, key_code}, 32'hD);
      release_key(3, 3);
      wait_scans(5);
      chk("releaseD_held", {31'h0, key_held}, 32'd0);
      press(1, 1);
      push(4'h5);
      wait_scans(6);
      chk("repress5_pending", exp_q.size(), 32'd0);
      release_key(1, 1);
      wait_scans(5);

      for (int i = 0; i < 7; i++) begin
         pressed[2] = ~pressed[2];
         repeat (SCAN * 3 / 2) @(negedge clk);
      end
      push(4'h7);
      wait_scans(6);
      chk("bounce7_pending", exp_q.size(), 32'd0);
      chk("bounce7_code", {28'h0, key_code}, 32'h7);
      chk("bounce7_held", {31'h0, key_held}, 32'd1);
      release_key(0, 2);
      wait_scans(5);

      press(0, 0);
      press(1, 0);
      wait_scans(6);
      chk("multi_held", {31'h0, key_held}, 32'd0);
      chk("multi_code", {28'h0, key_code}, 32'h7);
      release_key(1, 0);
      push(4'h1);
      wait_scans(6);
      chk("multi_to1_pending", exp_q.size(), 32'd0);
      chk("multi_to1_code", {28'h0, key_code}, 32'h1);
      chk("multi_to1_held", {31'h0, key_held}, 32'd1);
      release_key(0, 0);
      wait_scans(5);

      press(2, 2);
      push(4'h9);
      wait_scans(6);
      chk("press9_pending", exp_q.size(), 32'd0);
      #3 rst = 1'b1;
      #1;
      chk("midrst_col_n", {28'h0, col_n}, 32'h7);
      chk("midrst_key_code", {28'h0, key_code}, 32'h0);
      chk("midrst_key_valid", {31'h0, key_valid}, 32'd0);
      chk("midrst_key_held", {31'h0, key_held}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push(4'h9);
      wait_scans(6);
      chk("repress9_pending", exp_q.size(), 32'd0);
      chk("repress9_code", {28'h0, key_code}, 32'h9);
      chk("repress9_held", {31'h0, key_held}, 32'd1);
      release_key(2, 2);
      wait_scans(5);
      chk("final_pending", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
